// File: rtl/pc_pkg.sv
// Shared constants for the LC3 program counter with return-address stack.
package pc_pkg;

  // Next-PC select encodings driven by the control store.
  localparam logic [2:0] PCM_INC  = 3'd0;
  localparam logic [2:0] PCM_BUS  = 3'd1;
  localparam logic [2:0] PCM_ADDR = 3'd2;
  localparam logic [2:0] PCM_RET  = 3'd3;
  localparam logic [2:0] PCM_VEC  = 3'd4;

  // Default PC after reset.
  localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/pc_ras.sv
// Circular hardware return-address stack. The oldest entry is overwritten on overflow.
// Strobes arrive already qualified by the PC load enable.
module pc_ras #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we;
  logic [PtrW-1:0]  waddr;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntMax);
  assign count_o = cnt_q;
  assign top_o   = empty_o ? '0 : mem_q[sp_q];

  // Next pointer/count, write request and error events for this cycle's strobes.
  always_comb begin
    sp_d        = sp_q;
    cnt_d       = cnt_q;
    we          = 1'b0;
    waddr       = sp_q + 1'b1;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    if (push_i && pop_i) begin
      we = 1'b1;
      if (empty_o) begin
        // Nothing to replace: degenerate into a plain push, but flag the bad pop.
        sp_d        = sp_q + 1'b1;
        cnt_d       = CNT_W'(1);
        underflow_o = 1'b1;
      end else begin
        waddr = sp_q;
      end
    end else if (push_i) begin
      we   = 1'b1;
      sp_d = sp_q + 1'b1;
      if (full_o) begin
        overflow_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop_i) begin
      if (empty_o) begin
        underflow_o = 1'b1;
      end else begin
        sp_d  = sp_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are irrelevant after reset since count masks them.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[waddr] <= wdata_i;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// LC3 program counter with next-PC select and a hardware return-address stack.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = 16,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int unsigned       RAS_DEPTH    = 8,
  parameter int unsigned       CNT_W        = $clog2(RAS_DEPTH) + 1
) (
  input  logic             i_CLK,
  input  logic             i_Reset,
  input  logic             i_LD_PC_Control,
  input  logic [2:0]       i_PCMUX_Control,
  input  logic             i_Push,
  input  logic             i_Pop,
  input  logic             i_Clear_Err,
  input  logic [WIDTH-1:0] i_Bus,
  input  logic [WIDTH-1:0] i_Addr,
  input  logic [WIDTH-1:0] i_Vector,
  output logic [WIDTH-1:0] o_PC,
  output logic [WIDTH-1:0] o_RAS_Top,
  output logic [CNT_W-1:0] o_RAS_Count,
  output logic             o_RAS_Empty,
  output logic             o_RAS_Full,
  output logic             o_Overflow,
  output logic             o_Underflow
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] pc_inc;
  logic             ras_push, ras_pop;
  logic             ras_ovf_evt, ras_unf_evt;

  assign pc_inc   = pc_q + 1'b1;
  assign ras_push = i_LD_PC_Control & i_Push;
  assign ras_pop  = i_LD_PC_Control & i_Pop;

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH),
    .CNT_W    (CNT_W)
  ) u_ras (
    .clk_i      (i_CLK),
    .rst_i      (i_Reset),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .wdata_i    (pc_inc),
    .top_o      (o_RAS_Top),
    .count_o    (o_RAS_Count),
    .empty_o    (o_RAS_Empty),
    .full_o     (o_RAS_Full),
    .overflow_o (ras_ovf_evt),
    .underflow_o(ras_unf_evt)
  );

  // Next-PC mux and sticky error flags; a new error beats a simultaneous clear.
  always_comb begin
    pc_d = pc_q;
    if (i_LD_PC_Control) begin
      case (i_PCMUX_Control)
        PCM_INC:  pc_d = pc_inc;
        PCM_BUS:  pc_d = i_Bus;
        PCM_ADDR: pc_d = i_Addr;
        PCM_RET:  pc_d = o_RAS_Empty ? RESET_VECTOR : o_RAS_Top;
        PCM_VEC:  pc_d = i_Vector;
        default:  pc_d = pc_q;
      endcase
    end
    ovf_d = ras_ovf_evt | (ovf_q & ~i_Clear_Err);
    unf_d = ras_unf_evt | (unf_q & ~i_Clear_Err);
  end

  // PC and error flag registers.
  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign o_PC        = pc_q;
  assign o_Overflow  = ovf_q;
  assign o_Underflow = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int unsigned D  = 8;
  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, ld, push, pop, clr;
  logic [2:0]  sel;
  logic [15:0] bus, addr, vec;
  logic [15:0] pc, top;
  logic [3:0]  cnt;
  logic        empty, full, ovf, unf;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stack as a queue, newest entry at the back.
  logic [15:0] m_pc = RV;
  logic [15:0] m_stk[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  always #5 clk = ~clk;

  pc_stack_unit dut (
    .i_CLK          (clk),
    .i_Reset        (rst),
    .i_LD_PC_Control(ld),
    .i_PCMUX_Control(sel),
    .i_Push         (push),
    .i_Pop          (pop),
    .i_Clear_Err    (clr),
    .i_Bus          (bus),
    .i_Addr         (addr),
    .i_Vector       (vec),
    .o_PC           (pc),
    .o_RAS_Top      (top),
    .o_RAS_Count    (cnt),
    .o_RAS_Empty    (empty),
    .o_RAS_Full     (full),
    .o_Overflow     (ovf),
    .o_Underflow    (unf)
  );

  // Apply the current inputs to the model as the next clock edge will.
  task automatic model_apply();
    logic [15:0] inc;
    logic [15:0] mtop;
    logic        ovf_e, unf_e;
    ovf_e = 1'b0;
    unf_e = 1'b0;
    if (rst) begin
      m_pc = RV;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    if (ld) begin
      inc  = m_pc + 16'd1;
      mtop = (m_stk.size() > 0) ? m_stk[$] : 16'h0000;
      case (sel)
        3'd0: m_pc = inc;
        3'd1: m_pc = bus;
        3'd2: m_pc = addr;
        3'd3: m_pc = (m_stk.size() > 0) ? mtop : RV;
        3'd4: m_pc = vec;
        default: ;
      endcase
      if (push && pop) begin
        if (m_stk.size() == 0) begin
          m_stk.push_back(inc);
          unf_e = 1'b1;
        end else begin
          m_stk[m_stk.size()-1] = inc;
        end
      end else if (push) begin
        if (m_stk.size() == D) begin
          void'(m_stk.pop_front());
          ovf_e = 1'b1;
        end
        m_stk.push_back(inc);
      end else if (pop) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else unf_e = 1'b1;
      end
    end
    m_ovf = ovf_e | (m_ovf & ~clr);
    m_unf = unf_e | (m_unf & ~clr);
  endtask

  // One clock: update model, take the edge, settle outputs.
  task automatic cyc();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; ld = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0;
    sel = 3'd0; bus = '0; addr = '0; vec = '0;
  endtask

  task automatic load(input logic [2:0] s, input logic pu, input logic po);
    idle();
    ld = 1'b1; sel = s; push = pu; pop = po;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    n_checks++; if (pc !== RV) $display("FAIL reset_pc: got %h want %h", pc, RV); else n_pass++;
    n_checks++; if (cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", cnt); else n_pass++;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_empty_full: got %b%b want 10", empty, full); else n_pass++;
    n_checks++; if (top !== 16'h0) $display("FAIL reset_top: got %h want 0000", top); else n_pass++;
    n_checks++; if (ovf !== 1'b0 || unf !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", ovf, unf); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      load(3'd0, 1'b0, 1'b0);
      cyc();
      n_checks++; if (pc !== 16'(i)) $display("FAIL inc_seq: got %h want %h", pc, 16'(i)); else n_pass++;
    end
    n_checks++; if (empty !== 1'b1 || top !== 16'h0) $display("FAIL inc_empty: got empty=%b top=%h want 1 0000", empty, top); else n_pass++;
  endtask

  task automatic test_call_ret();
    load(3'd0, 1'b0, 1'b0); cyc(); cyc();  // PC 3 -> 5
    n_checks++; if (pc !== 16'h0005) $display("FAIL call_setup: got %h want 0005", pc); else n_pass++;
    load(3'd2, 1'b1, 1'b0); addr = 16'h0040; cyc();
    n_checks++; if (pc !== 16'h0040) $display("FAIL call_pc: got %h want 0040", pc); else n_pass++;
    n_checks++; if (cnt !== 4'd1 || top !== 16'h0006) $display("FAIL call_stack: got cnt=%0d top=%h want 1 0006", cnt, top); else n_pass++;
    load(3'd3, 1'b0, 1'b1); cyc();
    n_checks++; if (pc !== 16'h0006 || cnt !== 4'd0) $display("FAIL ret: got pc=%h cnt=%0d want 0006 0", pc, cnt); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [15:0] exp_pc;
    load(3'd1, 1'b0, 1'b0); bus = 16'h0010; cyc();
    for (int i = 0; i < 9; i++) begin
      load(3'd0, 1'b1, 1'b0); cyc();
    end
    n_checks++; if (cnt !== 4'd8 || full !== 1'b1) $display("FAIL ovf_full: got cnt=%0d full=%b want 8 1", cnt, full); else n_pass++;
    n_checks++; if (ovf !== 1'b1 || unf !== 1'b0) $display("FAIL ovf_flag: got ovf=%b unf=%b want 1 0", ovf, unf); else n_pass++;
    n_checks++; if (top !== 16'h0019) $display("FAIL ovf_top: got %h want 0019", top); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp_pc = 16'h0019 - 16'(i);
      load(3'd3, 1'b0, 1'b1); cyc();
      n_checks++; if (pc !== exp_pc) $display("FAIL ovf_pop_seq: got %h want %h", pc, exp_pc); else n_pass++;
    end
    n_checks++; if (empty !== 1'b1 || unf !== 1'b0) $display("FAIL ovf_drained: got empty=%b unf=%b want 1 0", empty, unf); else n_pass++;
    idle(); clr = 1'b1; cyc();
    n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_underflow();
    load(3'd3, 1'b0, 1'b1); cyc();
    n_checks++; if (pc !== RV || unf !== 1'b1) $display("FAIL unf_ret: got pc=%h unf=%b want %h 1", pc, unf, RV); else n_pass++;
    n_checks++; if (cnt !== 4'd0) $display("FAIL unf_cnt: got %0d want 0", cnt); else n_pass++;
    idle();
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++; if (unf !== 1'b1) $display("FAIL unf_sticky: got %b want 1", unf); else n_pass++;
    end
    clr = 1'b1; cyc();
    n_checks++; if (unf !== 1'b0) $display("FAIL unf_clear: got %b want 0", unf); else n_pass++;
    // Error event coinciding with clear keeps the flag set.
    load(3'd0, 1'b0, 1'b1); clr = 1'b1; cyc();
    n_checks++; if (unf !== 1'b1) $display("FAIL unf_clear_race: got %b want 1", unf); else n_pass++;
    idle(); clr = 1'b1; cyc();
  endtask

  task automatic test_push_pop();
    load(3'd1, 1'b0, 1'b0); bus = 16'h002F; cyc();
    load(3'd0, 1'b1, 1'b0); cyc(); cyc();
    n_checks++; if (cnt !== 4'd2 || top !== 16'h0031) $display("FAIL pp_setup: got cnt=%0d top=%h want 2 0031", cnt, top); else n_pass++;
    load(3'd1, 1'b0, 1'b0); bus = 16'h0050; cyc();
    load(3'd1, 1'b1, 1'b1); bus = 16'h0200; cyc();
    n_checks++; if (pc !== 16'h0200) $display("FAIL pp_pc: got %h want 0200", pc); else n_pass++;
    n_checks++; if (cnt !== 4'd2 || top !== 16'h0051) $display("FAIL pp_stack: got cnt=%0d top=%h want 2 0051", cnt, top); else n_pass++;
    n_checks++; if (ovf !== 1'b0 || unf !== 1'b0) $display("FAIL pp_flags: got %b%b want 00", ovf, unf); else n_pass++;
  endtask

  task automatic test_reset_priority();
    load(3'd4, 1'b1, 1'b0); vec = 16'h0180; rst = 1'b1; cyc();
    n_checks++; if (pc !== RV || cnt !== 4'd0) $display("FAIL rst_prio: got pc=%h cnt=%0d want %h 0", pc, cnt, RV); else n_pass++;
    load(3'd1, 1'b0, 1'b0); bus = 16'h0123; cyc();
    idle(); push = 1'b1; sel = 3'd2; addr = 16'h0777; cyc();
    idle(); pop = 1'b1; cyc();
    n_checks++; if (pc !== 16'h0123 || cnt !== 4'd0 || unf !== 1'b0) $display("FAIL hold: got pc=%h cnt=%0d unf=%b want 0123 0 0", pc, cnt, unf); else n_pass++;
    load(3'd1, 1'b0, 1'b0); bus = 16'hFFFF; cyc();
    load(3'd0, 1'b0, 1'b0); cyc();
    n_checks++; if (pc !== 16'h0000) $display("FAIL wrap: got %h want 0000", pc); else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      idle();
      rst  = ($urandom_range(99) < 2);
      ld   = ($urandom_range(99) < 85);
      sel  = 3'($urandom_range(7));
      push = ($urandom_range(99) < 45);
      pop  = ($urandom_range(99) < 35);
      clr  = ($urandom_range(99) < 8);
      bus  = 16'($urandom());
      addr = 16'($urandom());
      vec  = 16'($urandom());
      cyc();
      n_checks++;
      if (pc !== m_pc || cnt !== 4'(m_stk.size()) || empty !== (m_stk.size() == 0) ||
          full !== (m_stk.size() == D) || ovf !== m_ovf || unf !== m_unf ||
          top !== ((m_stk.size() > 0) ? m_stk[$] : 16'h0000)) begin
        if (bad < 10)
          $display("FAIL rand[%0d]: got pc=%h cnt=%0d top=%h e=%b f=%b o=%b u=%b want pc=%h cnt=%0d o=%b u=%b",
                   i, pc, cnt, top, empty, full, ovf, unf, m_pc, m_stk.size(), m_ovf, m_unf);
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_reset_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised next-generation program counter for the LC3 datapath.
- Holds the PC register, selects the next PC from five sources, and adds a hardware return-address stack (RAS) that saves return addresses on subroutine calls and restores them on return.
- Sits between the control store (load/select/push/pop strobes) and the datapath (bus, address adder, interrupt vector).
- Drives the PC onto the bus and into Addr1Mux.

Parameters:
- WIDTH, 16, width of PC, bus, address and stack entries.
- RESET_VECTOR, 16'h0000, PC value after reset; width is WIDTH.
- RAS_DEPTH, 8, number of stack entries; power of two, at least 2.
- CNT_W, $clog2(RAS_DEPTH)+1, width of the occupancy count.

Ports:
- i_CLK  in  1  system clock; all state updates on posedge.
- i_Reset  in  1  synchronous, active-high reset.
- i_LD_PC_Control  in  1  PC load enable; qualifies all other strobes.
- i_PCMUX_Control  in  3  next-PC select: 0 PC+1, 1 i_Bus, 2 i_Addr, 3 RAS top (return), 4 i_Vector, 5-7 reserved.
- i_Push  in  1  call: push PC+1 (pre-update) onto the RAS.
- i_Pop  in  1  return: pop the RAS.
- i_Clear_Err  in  1  clears the sticky error flags.
- i_Bus  in  WIDTH  bus value.
- i_Addr  in  WIDTH  address-adder value.
- i_Vector  in  WIDTH  interrupt/trap vector.
- o_PC  out  WIDTH  current PC.
- o_RAS_Top  out  WIDTH  top-of-stack value; 0 when empty.
- o_RAS_Count  out  CNT_W  number of valid entries.
- o_RAS_Empty  out  1  count == 0.
- o_RAS_Full  out  1  count == RAS_DEPTH.
- o_Overflow  out  1  sticky; set by a push while full.
- o_Underflow  out  1  sticky; set by a pop while empty.

Behaviour:
- Reset is synchronous, active-high, single clock i_CLK.
- Reset has priority over every other input on the same edge.
  - Sets o_PC = RESET_VECTOR.
  - Sets count = 0, stack pointer = 0, o_Overflow = o_Underflow = 0.
  - Stack storage contents are don't-care after reset.
- When i_LD_PC_Control = 0:
  - PC and stack hold.
  - i_Push and i_Pop are ignored.
  - i_Clear_Err still acts.
- When i_LD_PC_Control = 1, PC updates on the next edge. The load has one-cycle latency; o_PC is registered.
  - Select 0: PC+1, wrapping modulo 2^WIDTH (FFFF -> 0000).
  - Select 1: i_Bus.
  - Select 2: i_Addr.
  - Select 3: o_RAS_Top as sampled before the edge; if the stack is empty, RESET_VECTOR.
  - Select 4: i_Vector.
  - Selects 5-7: PC holds. The stack still acts on any qualified push/pop.
- Push (qualified by the load enable): writes the pre-update PC+1 at sp+1 (mod RAS_DEPTH); sp advances; count increments, saturating at RAS_DEPTH.
- Push while full: circular overwrite of the oldest entry; count stays at RAS_DEPTH; o_Overflow set.
- Pop (qualified):
  - Not empty: sp retreats, count decrements.
  - Empty: no pointer change; o_Underflow set.
- Push and pop together: replace the top entry with the pre-update PC+1. sp and count are unchanged and no error flag is raised. If the stack is empty, this behaves as a plain push (count becomes 1) and o_Underflow is set.
- Pop is independent of the select. Control normally pairs pop with select 3, but popping with another select simply discards the top entry.
- Error flags:
  - o_Overflow and o_Underflow hold until i_Clear_Err or reset.
  - If i_Clear_Err coincides with a new error event, the error wins and the flag stays 1.
- Status outputs:
  - o_RAS_Top, o_RAS_Empty, o_RAS_Full and o_RAS_Count derive combinationally from registered state.
  - o_RAS_Top = entry[sp] when count > 0, else 0.

Decomposition:
- Shared package pc_pkg holds:
  - the PCMUX select constants (PCM_INC=0, PCM_BUS=1, PCM_ADDR=2, PCM_RET=3, PCM_VEC=4);
  - the default RESET_VECTOR.
- One sub-module, pc_ras: the circular stack with parameters WIDTH and RAS_DEPTH.
  - Inputs: push, pop, wdata.
  - Outputs: top, count, empty, full, overflow event, underflow event.
- pc_stack_unit keeps the PC register, next-PC mux, sticky flags and strobe qualification.

Test Plan:
- Reset, then 3 cycles of load with select 0 -> o_PC = 0000, 0001, 0002, 0003; o_RAS_Empty = 1, o_RAS_Top = 0.
- At PC = 0005, load select 2 with i_Addr = 0040 and push -> PC = 0040, count = 1, top = 0006; then load select 3 with pop -> PC = 0006, count = 0.
- RAS_DEPTH = 8: perform 9 pushes, the first at PC = 0010 and each push incrementing PC by 1 -> count = 8, o_RAS_Full = 1, o_Overflow = 1; then 8 pops with select 3 -> PC sequence 0019, 0018 ... 0012 (the oldest entry, 0011, was lost).
- On an empty stack, load select 3 with pop -> PC = RESET_VECTOR, o_Underflow = 1; flag remains set for 5 idle cycles; i_Clear_Err -> 0 next cycle.
- With count = 2 and top = 0031, at PC = 0050 do push and pop together with select 1, i_Bus = 0200 -> PC = 0200, count = 2, top = 0051, no error flags.
- Assert reset in the same cycle as a load with push, select 4 and i_Vector = 0180 -> next cycle PC = RESET_VECTOR, count = 0; with i_LD_PC_Control = 0, push/pop strobes leave PC and count unchanged; PC = FFFF with select 0 -> 0000.
